mips_exec_ctrl: RTL and testbench

Instruction decode and execute stage of the single-cycle Harvard MIPS-I core. Combines the main control decoder, the ALU function decoder, the 32-bit ALU with branch comparator, and the HI/LO register pair. Takes the fetched instruction word and the two register-file read values. Produces the ALU result, the branch decision and every datapath select/enable for the surrounding PC, memory, mux and register-file logic.

---
 rtl/mips_exec_ctrl.sv | 272 +++++++++++++++++++++++++++
 tb/tb_mips_exec_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_exec_ctrl.sv
// Decode/execute stage of the single-cycle MIPS-I core: control decode, ALU, branch compare.
// Define MIPS_MULDIV_EN to add MULT/MULTU/DIV/DIVU, MFHI/MFLO/MTHI/MTLO and the HI/LO registers.
module mips_exec_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        active,
    input  logic [31:0] instr_readdata,
    input  logic [31:0] reg_data_a,
    input  logic [31:0] reg_data_b,
    output logic [31:0] alu_result,
    output logic        branch_taken,
    output logic [1:0]  pc_sel,
    output logic        reg_write_enable,
    output logic [1:0]  reg_addr_sel,
    output logic [1:0]  reg_data_sel,
    output logic        alu_sel,
    output logic        signextend_sel,
    output logic [1:0]  lwlr_sel,
    output logic        data_read,
    output logic        data_write,
    output logic [3:0]  byte_enable,
    output logic [1:0]  byte_offset
);
    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDIU   = 6'h09, OP_SLTI   = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D, OP_XORI   = 6'h0E, OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LWL   = 6'h22, OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24, OP_LHU    = 6'h25, OP_LWR   = 6'h26;
    localparam logic [5:0] OP_SB      = 6'h28, OP_SH     = 6'h29, OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03, FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR   = 6'h08, FN_JALR = 6'h09;
    localparam logic [5:0] FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO = 6'h12, FN_MTLO = 6'h13;
    localparam logic [5:0] FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV = 6'h1A, FN_DIVU = 6'h1B;
    localparam logic [5:0] FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

    localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;

    logic [5:0]  opcode, funct;
    logic [4:0]  rt, shamt;
    logic [31:0] a, b, imm_sext, imm_zext, addr;

    assign opcode   = instr_readdata[31:26];
    assign rt       = instr_readdata[20:16];
    assign shamt    = instr_readdata[10:6];
    assign funct    = instr_readdata[5:0];
    assign a        = reg_data_a;
    assign b        = reg_data_b;
    assign imm_sext = {{16{instr_readdata[15]}}, instr_readdata[15:0]};
    assign imm_zext = {16'd0, instr_readdata[15:0]};
    assign addr     = a + imm_sext;

`ifdef MIPS_MULDIV_EN
    localparam logic [2:0] MD_NONE = 3'd0, MD_MULT = 3'd1, MD_MULTU = 3'd2, MD_DIV = 3'd3;
    localparam logic [2:0] MD_DIVU = 3'd4, MD_MTHI = 3'd5, MD_MTLO = 3'd6;

    logic [2:0]  md_op;
    logic [31:0] hi_q, lo_q, hi_d, lo_d;
`endif

    logic [31:0] result;
    logic        taken, wr_en, rd_en, st_en;

    always_comb begin
        result         = 32'd0;
        taken          = 1'b0;
        pc_sel         = 2'b00;
        wr_en          = 1'b0;
        reg_addr_sel   = 2'b00;
        reg_data_sel   = 2'b00;
        alu_sel        = 1'b0;
        signextend_sel = 1'b0;
        lwlr_sel       = 2'b00;
        rd_en          = 1'b0;
        st_en          = 1'b0;
        byte_enable    = 4'b0000;
`ifdef MIPS_MULDIV_EN
        md_op          = MD_NONE;
`endif
        // An all-zero word would otherwise decode as SLL r0 and raise a write strobe.
        if (instr_readdata != 32'd0) begin
            case (opcode)
                OP_SPECIAL: begin
                    wr_en        = 1'b1;
                    reg_addr_sel = 2'b01;
                    case (funct)
                        FN_SLL:  result = b << shamt;
                        FN_SRL:  result = b >> shamt;
                        FN_SRA:  result = $signed(b) >>> shamt;
                        FN_SLLV: result = b << a[4:0];
                        FN_SRLV: result = b >> a[4:0];
                        FN_SRAV: result = $signed(b) >>> a[4:0];
                        FN_ADDU: result = a + b;
                        FN_SUBU: result = a - b;
                        FN_AND:  result = a & b;
                        FN_OR:   result = a | b;
                        FN_XOR:  result = a ^ b;
                        FN_NOR:  result = ~(a | b);
                        FN_SLT:  result = {31'd0, $signed(a) < $signed(b)};
                        FN_SLTU: result = {31'd0, a < b};
                        FN_JR: begin
                            wr_en        = 1'b0;
                            reg_addr_sel = 2'b00;
                            pc_sel       = 2'b11;
                        end
                        FN_JALR: begin
                            pc_sel       = 2'b11;
                            reg_data_sel = 2'b10;
                        end
`ifdef MIPS_MULDIV_EN
                        FN_MFHI: result = hi_q;
                        FN_MFLO: result = lo_q;
                        FN_MTHI, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                            wr_en        = 1'b0;
                            reg_addr_sel = 2'b00;
                            case (funct)
                                FN_MTHI:  md_op = MD_MTHI;
                                FN_MTLO:  md_op = MD_MTLO;
                                FN_MULT:  md_op = MD_MULT;
                                FN_MULTU: md_op = MD_MULTU;
                                FN_DIV:   md_op = MD_DIV;
                                default:  md_op = MD_DIVU;
                            endcase
                        end
`endif
                        default: begin
                            wr_en        = 1'b0;
                            reg_addr_sel = 2'b00;
                        end
                    endcase
                end
                OP_REGIMM: begin
                    if (rt == RT_BLTZ || rt == RT_BLTZAL) begin
                        pc_sel = 2'b01;
                        taken  = a[31];
                    end else if (rt == RT_BGEZ || rt == RT_BGEZAL) begin
                        pc_sel = 2'b01;
                        taken  = ~a[31];
                    end
                    // The linking forms write r31 whether or not the branch is taken.
                    if (rt == RT_BLTZAL || rt == RT_BGEZAL) begin
                        wr_en        = 1'b1;
                        reg_addr_sel = 2'b10;
                        reg_data_sel = 2'b10;
                    end
                end
                OP_J:   pc_sel = 2'b10;
                OP_JAL: begin
                    pc_sel       = 2'b10;
                    wr_en        = 1'b1;
                    reg_addr_sel = 2'b10;
                    reg_data_sel = 2'b10;
                end
                OP_BEQ: begin
                    pc_sel = 2'b01;
                    taken  = (a == b);
                end
                OP_BNE: begin
                    pc_sel = 2'b01;
                    taken  = (a != b);
                end
                OP_BLEZ: begin
                    pc_sel = 2'b01;
                    taken  = a[31] | (a == 32'd0);
                end
                OP_BGTZ: begin
                    pc_sel = 2'b01;
                    taken  = ~a[31] & (a != 32'd0);
                end
                OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                    wr_en          = 1'b1;
                    alu_sel        = 1'b1;
                    signextend_sel = 1'b1;
                    case (opcode)
                        OP_ADDIU: result = a + imm_sext;
                        OP_SLTI:  result = {31'd0, $signed(a) < $signed(imm_sext)};
                        default:  result = {31'd0, a < imm_sext};
                    endcase
                end
                OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                    wr_en   = 1'b1;
                    alu_sel = 1'b1;
                    case (opcode)
                        OP_ANDI: result = a & imm_zext;
                        OP_ORI:  result = a | imm_zext;
                        OP_XORI: result = a ^ imm_zext;
                        default: result = {instr_readdata[15:0], 16'd0};
                    endcase
                end
                OP_LB, OP_LH, OP_LBU, OP_LHU, OP_LW, OP_LWL, OP_LWR: begin
                    result         = addr;
                    wr_en          = 1'b1;
                    alu_sel        = 1'b1;
                    rd_en          = 1'b1;
                    byte_enable    = 4'b1111;
                    signextend_sel = (opcode != OP_LBU) && (opcode != OP_LHU);
                    reg_data_sel   = (opcode == OP_LW || opcode == OP_LWL || opcode == OP_LWR) ? 2'b11 : 2'b01;
                    if (opcode == OP_LWL) lwlr_sel = 2'b11;
                    if (opcode == OP_LWR) lwlr_sel = 2'b10;
                end
                OP_SB, OP_SH, OP_SW: begin
                    result         = addr;
                    alu_sel        = 1'b1;
                    signextend_sel = 1'b1;
                    st_en          = 1'b1;
                    case (opcode)
                        OP_SB:   byte_enable = 4'b0001 << addr[1:0];
                        OP_SH:   byte_enable = addr[1] ? 4'b1100 : 4'b0011;
                        default: byte_enable = 4'b1111;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign alu_result       = result;
    assign branch_taken     = taken;
    assign byte_offset      = result[1:0];
    assign reg_write_enable = wr_en & active;
    assign data_read        = rd_en & active;
    assign data_write       = st_en & active;

`ifdef MIPS_MULDIV_EN
    logic [63:0] prod_s, prod_u;
    logic [31:0] div_b, quot_s, rem_s;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};
    assign div_b  = (b == 32'd0) ? 32'd1 : b;
    assign quot_s = $signed(a) / $signed(div_b);
    assign rem_s  = $signed(a) % $signed(div_b);

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        case (md_op)
            MD_MULT:  {hi_d, lo_d} = prod_s;
            MD_MULTU: {hi_d, lo_d} = prod_u;
            MD_DIV: if (b != 32'd0) begin
                lo_d = quot_s;
                hi_d = rem_s;
            end
            MD_DIVU: if (b != 32'd0) begin
                lo_d = a / div_b;
                hi_d = a % div_b;
            end
            MD_MTHI:  hi_d = a;
            MD_MTLO:  lo_d = a;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (clk_enable && active) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end
`else
    // Without HI/LO the core clock and enable have no sink in this stage.
    logic unused_hilo_inputs;
    assign unused_hilo_inputs = clk ^ reset ^ clk_enable;
`endif

endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Bench for mips_exec_ctrl: directed and random instructions against a mnemonic-level model.
// Expectations are queued at issue time and a negedge monitor pops and compares them.
module tb_mips_exec_ctrl;
    logic        clk = 1'b0;
    logic        reset, clk_enable, active;
    logic [31:0] instr_readdata, reg_data_a, reg_data_b;
    logic [31:0] alu_result;
    logic        branch_taken, reg_write_enable, alu_sel, signextend_sel, data_read, data_write;
    logic [1:0]  pc_sel, reg_addr_sel, reg_data_sel, lwlr_sel, byte_offset;
    logic [3:0]  byte_enable;

    mips_exec_ctrl dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .active(active),
        .instr_readdata(instr_readdata), .reg_data_a(reg_data_a), .reg_data_b(reg_data_b),
        .alu_result(alu_result), .branch_taken(branch_taken), .pc_sel(pc_sel),
        .reg_write_enable(reg_write_enable), .reg_addr_sel(reg_addr_sel),
        .reg_data_sel(reg_data_sel), .alu_sel(alu_sel), .signextend_sel(signextend_sel),
        .lwlr_sel(lwlr_sel), .data_read(data_read), .data_write(data_write),
        .byte_enable(byte_enable), .byte_offset(byte_offset)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic        bt;
        logic [1:0]  pc;
        logic        rwe;
        logic [1:0]  ras;
        logic [1:0]  rds;
        logic        asel;
        logic        sx;
        logic [1:0]  lwlr;
        logic        dr;
        logic        dw;
        logic [3:0]  be;
        logic [1:0]  bo;
    } exp_t;

    typedef enum int {
        M_NOP, M_SLL, M_SRL, M_SRA, M_SLLV, M_SRLV, M_SRAV, M_JR, M_JALR,
        M_MFHI, M_MTHI, M_MFLO, M_MTLO, M_MULT, M_MULTU, M_DIV, M_DIVU,
        M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
        M_BLTZ, M_BGEZ, M_BLTZAL, M_BGEZAL, M_J, M_JAL, M_BEQ, M_BNE, M_BLEZ, M_BGTZ,
        M_ADDIU, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LUI,
        M_LB, M_LH, M_LWL, M_LW, M_LBU, M_LHU, M_LWR, M_SB, M_SH, M_SW
    } mn_t;

    exp_t        exp_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    function automatic mn_t classify(input logic [31:0] w);
        if (w == 32'd0) return M_NOP;
        case (w[31:26])
            6'h00: case (w[5:0])
                6'h00: return M_SLL;   6'h02: return M_SRL;   6'h03: return M_SRA;
                6'h04: return M_SLLV;  6'h06: return M_SRLV;  6'h07: return M_SRAV;
                6'h08: return M_JR;    6'h09: return M_JALR;
                6'h21: return M_ADDU;  6'h23: return M_SUBU;  6'h24: return M_AND;
                6'h25: return M_OR;    6'h26: return M_XOR;   6'h27: return M_NOR;
                6'h2A: return M_SLT;   6'h2B: return M_SLTU;
`ifdef MIPS_MULDIV_EN
                6'h10: return M_MFHI;  6'h11: return M_MTHI;  6'h12: return M_MFLO;
                6'h13: return M_MTLO;  6'h18: return M_MULT;  6'h19: return M_MULTU;
                6'h1A: return M_DIV;   6'h1B: return M_DIVU;
`endif
                default: return M_NOP;
            endcase
            6'h01: case (w[20:16])
                5'h00: return M_BLTZ;   5'h01: return M_BGEZ;
                5'h10: return M_BLTZAL; 5'h11: return M_BGEZAL;
                default: return M_NOP;
            endcase
            6'h02: return M_J;     6'h03: return M_JAL;   6'h04: return M_BEQ;
            6'h05: return M_BNE;   6'h06: return M_BLEZ;  6'h07: return M_BGTZ;
            6'h09: return M_ADDIU; 6'h0A: return M_SLTI;  6'h0B: return M_SLTIU;
            6'h0C: return M_ANDI;  6'h0D: return M_ORI;   6'h0E: return M_XORI;
            6'h0F: return M_LUI;   6'h20: return M_LB;    6'h21: return M_LH;
            6'h22: return M_LWL;   6'h23: return M_LW;    6'h24: return M_LBU;
            6'h25: return M_LHU;   6'h26: return M_LWR;   6'h28: return M_SB;
            6'h29: return M_SH;    6'h2B: return M_SW;
            default: return M_NOP;
        endcase
        return M_NOP;
    endfunction

    function automatic exp_t model(input logic [31:0] w, input logic [31:0] a,
                                   input logic [31:0] b, input logic act);
        exp_t        e;
        mn_t         m;
        int          sa, sb, sse;
        logic [31:0] se, ze;
        int unsigned sh, vs;
        m   = classify(w);
        sa  = a;
        sb  = b;
        se  = {{16{w[15]}}, w[15:0]};
        ze  = {16'd0, w[15:0]};
        sse = se;
        sh  = {27'd0, w[10:6]};
        vs  = {27'd0, a[4:0]};
        e   = '0;
        case (m)
            M_SLL:   e.res = b << sh;
            M_SRL:   e.res = b >> sh;
            M_SRA:   e.res = sb >>> sh;
            M_SLLV:  e.res = b << vs;
            M_SRLV:  e.res = b >> vs;
            M_SRAV:  e.res = sb >>> vs;
            M_ADDU:  e.res = a + b;
            M_SUBU:  e.res = a - b;
            M_AND:   e.res = a & b;
            M_OR:    e.res = a | b;
            M_XOR:   e.res = a ^ b;
            M_NOR:   e.res = ~(a | b);
            M_SLT:   e.res = (sa < sb) ? 32'd1 : 32'd0;
            M_SLTU:  e.res = (a < b) ? 32'd1 : 32'd0;
            M_ADDIU: e.res = a + se;
            M_SLTI:  e.res = (sa < sse) ? 32'd1 : 32'd0;
            M_SLTIU: e.res = (a < se) ? 32'd1 : 32'd0;
            M_ANDI:  e.res = a & ze;
            M_ORI:   e.res = a | ze;
            M_XORI:  e.res = a ^ ze;
            M_LUI:   e.res = ze << 16;
            M_MFHI:  e.res = m_hi;
            M_MFLO:  e.res = m_lo;
            default: ;
        endcase
        if (m inside {M_SLL, M_SRL, M_SRA, M_SLLV, M_SRLV, M_SRAV, M_ADDU, M_SUBU, M_AND,
                      M_OR, M_XOR, M_NOR, M_SLT, M_SLTU, M_MFHI, M_MFLO}) begin
            e.rwe = 1'b1;
            e.ras = 2'b01;
        end
        if (m inside {M_ADDIU, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LUI}) begin
            e.rwe  = 1'b1;
            e.asel = 1'b1;
            e.sx   = (m inside {M_ADDIU, M_SLTI, M_SLTIU});
        end
        if (m inside {M_LB, M_LH, M_LBU, M_LHU, M_LW, M_LWL, M_LWR}) begin
            e.res  = a + se;
            e.rwe  = 1'b1;
            e.asel = 1'b1;
            e.dr   = 1'b1;
            e.be   = 4'b1111;
            e.sx   = !(m inside {M_LBU, M_LHU});
            e.rds  = (m inside {M_LW, M_LWL, M_LWR}) ? 2'b11 : 2'b01;
            e.lwlr = (m == M_LWL) ? 2'b11 : (m == M_LWR) ? 2'b10 : 2'b00;
        end
        if (m inside {M_SB, M_SH, M_SW}) begin
            e.res  = a + se;
            e.asel = 1'b1;
            e.sx   = 1'b1;
            e.dw   = 1'b1;
            if (m == M_SW)      e.be = 4'b1111;
            else if (m == M_SH) e.be = e.res[1] ? 4'b1100 : 4'b0011;
            else                e.be = 4'b0001 << e.res[1:0];
        end
        if (m inside {M_BEQ, M_BNE, M_BLEZ, M_BGTZ, M_BLTZ, M_BGEZ, M_BLTZAL, M_BGEZAL}) begin
            e.pc = 2'b01;
            case (m)
                M_BEQ:   e.bt = (a == b);
                M_BNE:   e.bt = (a != b);
                M_BLEZ:  e.bt = (sa <= 0);
                M_BGTZ:  e.bt = (sa > 0);
                M_BLTZ, M_BLTZAL: e.bt = (sa < 0);
                default: e.bt = (sa >= 0);
            endcase
        end
        if (m inside {M_BLTZAL, M_BGEZAL, M_JAL}) begin
            e.rwe = 1'b1;
            e.ras = 2'b10;
            e.rds = 2'b10;
        end
        if (m == M_JALR) begin
            e.rwe = 1'b1;
            e.ras = 2'b01;
            e.rds = 2'b10;
        end
        if (m inside {M_J, M_JAL}) e.pc = 2'b10;
        if (m inside {M_JR, M_JALR}) e.pc = 2'b11;
        if (!act) begin
            e.rwe = 1'b0;
            e.dr  = 1'b0;
            e.dw  = 1'b0;
        end
        e.bo = e.res[1:0];
        return e;
    endfunction

    // Effect on HI/LO of the coming rising edge.
    function automatic void model_edge(input logic [31:0] w, input logic [31:0] a,
                                       input logic [31:0] b, input logic act,
                                       input logic ce, input logic rst);
        mn_t         m;
        longint      ps;
        logic [63:0] pu;
        int          sa, sb;
        m  = classify(w);
        sa = a;
        sb = b;
        if (rst) begin
            m_hi = 32'd0;
            m_lo = 32'd0;
        end else if (ce && act) begin
            case (m)
                M_MULT: begin
                    ps = longint'($signed(a)) * longint'($signed(b));
                    {m_hi, m_lo} = ps;
                end
                M_MULTU: begin
                    pu = {32'd0, a} * {32'd0, b};
                    {m_hi, m_lo} = pu;
                end
                M_DIV: if (b != 32'd0) begin
                    m_lo = sa / sb;
                    m_hi = sa % sb;
                end
                M_DIVU: if (b != 32'd0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
                M_MTHI: m_hi = a;
                M_MTLO: m_lo = a;
                default: ;
            endcase
        end
    endfunction

    task automatic issue(input string nm, input logic [31:0] w, input logic [31:0] a,
                         input logic [31:0] b, input logic act, input logic ce, input logic rst);
        @(posedge clk);
        #1;
        instr_readdata = w;
        reg_data_a     = a;
        reg_data_b     = b;
        active         = act;
        clk_enable     = ce;
        reset          = rst;
        exp_q.push_back(model(w, a, b, act));
        name_q.push_back(nm);
        model_edge(w, a, b, act, ce, rst);
    endtask

    task automatic run(input string nm, input logic [31:0] w, input logic [31:0] a,
                       input logic [31:0] b);
        issue(nm, w, a, b, 1'b1, 1'b1, 1'b0);
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] sh);
        return {6'd0, 5'd1, 5'd2, 5'd3, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    function automatic logic [5:0] pick_funct(input int i);
        case (i)
            0: return 6'h00;  1: return 6'h02;  2: return 6'h03;  3: return 6'h04;
            4: return 6'h06;  5: return 6'h07;  6: return 6'h08;  7: return 6'h09;
            8: return 6'h10;  9: return 6'h11; 10: return 6'h12; 11: return 6'h13;
           12: return 6'h18; 13: return 6'h19; 14: return 6'h1A; 15: return 6'h1B;
           16: return 6'h21; 17: return 6'h23; 18: return 6'h24; 19: return 6'h25;
           20: return 6'h26; 21: return 6'h27; 22: return 6'h2A; default: return 6'h2B;
        endcase
    endfunction

    function automatic logic [5:0] pick_op(input int i);
        case (i)
            0: return 6'h02;  1: return 6'h03;  2: return 6'h04;  3: return 6'h05;
            4: return 6'h06;  5: return 6'h07;  6: return 6'h09;  7: return 6'h0A;
            8: return 6'h0B;  9: return 6'h0C; 10: return 6'h0D; 11: return 6'h0E;
           12: return 6'h0F; 13: return 6'h20; 14: return 6'h21; 15: return 6'h22;
           16: return 6'h23; 17: return 6'h24; 18: return 6'h25; 19: return 6'h26;
           20: return 6'h28; 21: return 6'h29; default: return 6'h2B;
        endcase
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'($urandom_range(0, 20));
            2: return -32'($urandom_range(1, 20));
            3: return ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e, got;
            string nm;
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {alu_result, branch_taken, pc_sel, reg_write_enable, reg_addr_sel,
                   reg_data_sel, alu_sel, signextend_sel, lwlr_sel, data_read, data_write,
                   byte_enable, byte_offset};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL %s instr=%h: actual res=%h ctl=%h, required res=%h ctl=%h",
                         nm, instr_readdata, got.res, got[19:0], e.res, e[19:0]);
            end
        end
    end

    initial begin
        logic [31:0] w, a, b;
        int          k;
        reset          = 1'b1;
        clk_enable     = 1'b1;
        active         = 1'b1;
        instr_readdata = 32'd0;
        reg_data_a     = 32'd0;
        reg_data_b     = 32'd0;

        issue("reset_nop0", 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
        issue("reset_nop1", 32'd0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b1, 1'b1);
        run("addu_ovf",  rtype(6'h21, 5'd0), 32'h7FFF_FFFF, 32'd1);
        run("slt",       rtype(6'h2A, 5'd0), 32'hFFFF_FFFF, 32'd1);
        run("sltu",      rtype(6'h2B, 5'd0), 32'hFFFF_FFFF, 32'd1);
        run("sra_shamt", rtype(6'h03, 5'd4), 32'd0, 32'h8000_00F0);
        run("mult",      rtype(6'h18, 5'd0), 32'hFFFF_FFFE, 32'd3);
        run("mfhi_mult", rtype(6'h10, 5'd0), 32'd0, 32'd0);
        run("mflo_mult", rtype(6'h12, 5'd0), 32'd0, 32'd0);
        issue("reset_pulse", 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
        run("mflo_rst",  rtype(6'h12, 5'd0), 32'd0, 32'd0);
        run("mthi",      rtype(6'h11, 5'd0), 32'h0000_1234, 32'd0);
        run("div_zero",  rtype(6'h1A, 5'd0), 32'd77, 32'd0);
        run("mfhi_div0", rtype(6'h10, 5'd0), 32'd0, 32'd0);
        run("div_neg",   rtype(6'h1A, 5'd0), -32'd7, 32'd2);
        run("mfhi_div",  rtype(6'h10, 5'd0), 32'd0, 32'd0);
        run("mflo_div",  rtype(6'h12, 5'd0), 32'd0, 32'd0);
        issue("mtlo_noce", rtype(6'h13, 5'd0), 32'h5555_5555, 32'd0, 1'b1, 1'b0, 1'b0);
        issue("mtlo_inact", rtype(6'h13, 5'd0), 32'h6666_6666, 32'd0, 1'b0, 1'b1, 1'b0);
        run("mflo_held", rtype(6'h12, 5'd0), 32'd0, 32'd0);
        run("beq_taken", itype(6'h04, 16'h0010), 32'd5, 32'd5);
        run("bgezal_nt", {6'h01, 5'd1, 5'h11, 16'h0004}, 32'hFFFF_FFFF, 32'd0);
        run("sb_off3",   itype(6'h28, 16'd3), 32'h0000_1000, 32'd0);
        run("sh_off2",   itype(6'h29, 16'd2), 32'h0000_1000, 32'd0);
        run("lwl",       itype(6'h22, 16'hFFFF), 32'h0000_2000, 32'd0);
        run("lhu",       itype(6'h25, 16'h0006), 32'h0000_2000, 32'd0);
        issue("sw_inactive", itype(6'h2B, 16'd4), 32'h0000_1000, 32'd5, 1'b0, 1'b1, 1'b0);
        run("zero_word", 32'd0, 32'd123, 32'd456);
        run("jalr",      rtype(6'h09, 5'd0), 32'h0040_0000, 32'd0);

        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 9);
            w = $urandom;
            if (k < 4) begin
                w[31:26] = 6'h00;
                w[5:0]   = (k < 3) ? pick_funct($urandom_range(0, 23)) : 6'($urandom);
            end else if (k == 4) begin
                w[31:26] = 6'h01;
                if ($urandom_range(0, 3) != 0)
                    w[20:16] = {$urandom_range(0, 1) != 0, 3'b000, $urandom_range(0, 1) != 0};
            end else if (k < 9) begin
                w[31:26] = ($urandom_range(0, 4) != 0) ? pick_op($urandom_range(0, 22))
                                                        : 6'($urandom);
            end
            a = rnd_val();
            b = ($urandom_range(0, 4) == 0) ? a : rnd_val();
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            issue($sformatf("rand%0d", i), w, a, b, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 6) != 0, $urandom_range(0, 39) == 0);
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: actual pending=%0d required pending=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
